// File: rtl/gomoku_pkg.sv
// Shared types and constants for the gomoku move engine: FSM and direction
// encodings, per-direction step deltas and cell-code sizing.
package gomoku_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_SCAN} state_e;
    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;

    localparam int EMPTY = 0;

    // (dx, dy) per direction, indexed by dir_e: row, column, diagonal, anti-diagonal
    localparam int DIR_DX [4] = '{0, 1, 1, 1};
    localparam int DIR_DY [4] = '{1, 0, 1, -1};

    function automatic int cell_w(input int players);
        return $clog2(players + 1);
    endfunction

endpackage

// File: rtl/gomoku_run_counter.sv
// Consecutive-stone run counter for one scan line, with a sticky win flag that
// remembers any run reaching WIN_LEN earlier in the current move.
module gomoku_run_counter #(
    parameter int WIN_LEN = 5,
    localparam int RUN_W = $clog2(2 * WIN_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             step,
    input  logic             clear,
    input  logic             match,
    output logic [RUN_W-1:0] run,
    output logic             win
);

    logic [RUN_W-1:0] run_q, run_d;
    logic             win_q, win_d;

    // run reports the length including the cell being stepped this cycle
    always_comb begin
        run_d = run_q;
        win_d = win_q;
        if (flush) begin
            run_d = '0;
            win_d = 1'b0;
        end else if (step) begin
            if (!match) begin
                run_d = '0;
            end else if (clear) begin
                run_d = RUN_W'(1);
            end else begin
                run_d = run_q + RUN_W'(1);
            end
            if (int'(run_d) >= WIN_LEN) begin
                win_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q <= '0;
            win_q <= 1'b0;
        end else begin
            run_q <= run_d;
            win_q <= win_d;
        end
    end

    assign run = run_d;
    assign win = win_q;

endmodule

// File: rtl/gomoku_move_engine.sv
// Gomoku move engine: board store, move validation, win scan around the last
// stone and turn sequencing; one scanned cell per cycle, result on the last SCAN edge.
module gomoku_move_engine
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = 16,
    parameter int PLAYERS = 2,
    parameter int WIN_LEN = 5,
    localparam int COORD_W = $clog2(BOARD_N),
    localparam int CELL_W  = cell_w(PLAYERS),
    localparam int TURN_W  = $clog2(PLAYERS),
    localparam int CNT_W   = $clog2(BOARD_N * BOARD_N + 1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [COORD_W-1:0]                coord_x,
    input  logic [COORD_W-1:0]                coord_y,
    input  logic                              put,
    input  logic                              new_game,
    output logic [BOARD_N*BOARD_N*CELL_W-1:0] board,
    output logic [TURN_W-1:0]                 turn,
    output logic                              busy,
    output logic                              move_ok,
    output logic                              move_reject,
    output logic [CELL_W-1:0]                 winner,
    output logic                              draw,
    output logic                              game_over,
    output logic [CNT_W-1:0]                  move_count
);

    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int K_W    = $clog2(2 * WIN_LEN - 1);
    localparam int RUN_W  = $clog2(2 * WIN_LEN);
    localparam logic [K_W-1:0] K_LAST = K_W'(2 * WIN_LEN - 2);

    logic [CELL_W-1:0]  cells_q [CELLS];
    logic [CELL_W-1:0]  cells_d [CELLS];
    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [TURN_W-1:0]  turn_q, turn_d;
    logic [CELL_W-1:0]  winner_q, winner_d;
    logic [CNT_W-1:0]   move_count_q, move_count_d;
    logic               busy_q, busy_d, move_ok_q, move_ok_d, move_reject_q, move_reject_d;
    logic               draw_q, draw_d, game_over_q, game_over_d;

    logic [CELL_W-1:0]  mover, chk_cell, scan_cell;
    logic [ADDR_W-1:0]  chk_addr, scan_addr;
    logic               in_range, on_board, scan_match;
    int                 off, sx, sy;
    logic               run_flush, run_step, run_clear, run_win;
    logic [RUN_W-1:0]   run_len;

    assign mover = CELL_W'(turn_q) + CELL_W'(1);

    // Captured-coordinate cell for CHECK and the offset cell walked by SCAN
    always_comb begin
        in_range  = (int'(cx_q) < BOARD_N) && (int'(cy_q) < BOARD_N);
        chk_addr  = ADDR_W'(int'(cx_q) * BOARD_N + int'(cy_q));
        chk_cell  = in_range ? cells_q[chk_addr] : CELL_W'(EMPTY);
        off       = int'(k_q) - (WIN_LEN - 1);
        sx        = int'(cx_q) + DIR_DX[dir_q] * off;
        sy        = int'(cy_q) + DIR_DY[dir_q] * off;
        on_board  = (sx >= 0) && (sx < BOARD_N) && (sy >= 0) && (sy < BOARD_N);
        scan_addr = ADDR_W'(sx * BOARD_N + sy);
        scan_cell = on_board ? cells_q[scan_addr] : CELL_W'(EMPTY);
        scan_match = on_board && (scan_cell == mover);
    end

    gomoku_run_counter #(
        .WIN_LEN(WIN_LEN)
    ) u_run (
        .clock (clock),
        .reset (reset),
        .flush (run_flush),
        .step  (run_step),
        .clear (run_clear),
        .match (scan_match),
        .run   (run_len),
        .win   (run_win)
    );

    always_comb begin
        state_d       = state_q;
        cells_d       = cells_q;
        dir_d         = dir_q;
        k_d           = k_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        turn_d        = turn_q;
        winner_d      = winner_q;
        draw_d        = draw_q;
        move_count_d  = move_count_q;
        move_ok_d     = 1'b0;
        move_reject_d = 1'b0;
        run_flush     = 1'b0;
        run_step      = 1'b0;
        run_clear     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (put) begin
                    cx_d    = coord_x;
                    cy_d    = coord_y;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                run_flush = 1'b1;
                if (!in_range || chk_cell != CELL_W'(EMPTY) || game_over_q) begin
                    move_reject_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cells_d[chk_addr] = mover;
                    move_count_d      = move_count_q + CNT_W'(1);
                    dir_d             = DIR_H;
                    k_d               = '0;
                    state_d           = ST_SCAN;
                end
            end
            ST_SCAN: begin
                run_step  = 1'b1;
                run_clear = (k_q == '0);
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (dir_q == DIR_A) begin
                        move_ok_d = 1'b1;
                        state_d   = ST_IDLE;
                        // the last scanned cell is not yet in the sticky flag
                        if (run_win || int'(run_len) >= WIN_LEN) begin
                            winner_d = mover;
                        end else if (int'(move_count_q) == CELLS) begin
                            draw_d = 1'b1;
                        end else begin
                            turn_d = (int'(turn_q) == PLAYERS - 1) ? '0 : turn_q + TURN_W'(1);
                        end
                    end else begin
                        dir_d = dir_e'(dir_q + 2'd1);
                    end
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (new_game) begin
            state_d       = ST_IDLE;
            cells_d       = '{default: '0};
            turn_d        = '0;
            winner_d      = '0;
            draw_d        = 1'b0;
            move_count_d  = '0;
            move_ok_d     = 1'b0;
            move_reject_d = 1'b0;
            run_flush     = 1'b1;
        end
        game_over_d = (winner_d != '0) || draw_d;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cells_q       <= '{default: '0};
            dir_q         <= DIR_H;
            k_q           <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            turn_q        <= '0;
            winner_q      <= '0;
            draw_q        <= 1'b0;
            game_over_q   <= 1'b0;
            move_count_q  <= '0;
            busy_q        <= 1'b0;
            move_ok_q     <= 1'b0;
            move_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cells_q       <= cells_d;
            dir_q         <= dir_d;
            k_q           <= k_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            turn_q        <= turn_d;
            winner_q      <= winner_d;
            draw_q        <= draw_d;
            game_over_q   <= game_over_d;
            move_count_q  <= move_count_d;
            busy_q        <= busy_d;
            move_ok_q     <= move_ok_d;
            move_reject_q <= move_reject_d;
        end
    end

    always_comb begin
        board = '0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            board[i*CELL_W +: CELL_W] = cells_q[i];
        end
    end

    assign turn        = turn_q;
    assign busy        = busy_q;
    assign move_ok     = move_ok_q;
    assign move_reject = move_reject_q;
    assign winner      = winner_q;
    assign draw        = draw_q;
    assign game_over   = game_over_q;
    assign move_count  = move_count_q;

endmodule

// File: tb/tb_gomoku_move_engine.sv
// Directed bench for gomoku_move_engine: default 16x16/2-player, 4x4/3-player
// and 5x5 instances with hand-computed expected boards, results and latencies.
module tb_gomoku_move_engine;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [3:0]   coord_x_a, coord_y_a;
    logic         put_a, new_game_a;
    logic [511:0] board_a;
    logic [0:0]   turn_a;
    logic         busy_a, move_ok_a, move_reject_a, draw_a, game_over_a;
    logic [1:0]   winner_a;
    logic [8:0]   move_count_a;

    logic [1:0]   coord_x_b, coord_y_b;
    logic         put_b, new_game_b;
    logic [31:0]  board_b;
    logic [1:0]   turn_b;
    logic         busy_b, move_ok_b, move_reject_b, draw_b, game_over_b;
    logic [1:0]   winner_b;
    logic [4:0]   move_count_b;

    logic [2:0]   coord_x_c, coord_y_c;
    logic         put_c, new_game_c;
    logic [49:0]  board_c;
    logic [0:0]   turn_c;
    logic         busy_c, move_ok_c, move_reject_c, draw_c, game_over_c;
    logic [1:0]   winner_c;
    logic [4:0]   move_count_c;

    gomoku_move_engine dut_a (
        .clock(clock), .reset(reset), .coord_x(coord_x_a), .coord_y(coord_y_a),
        .put(put_a), .new_game(new_game_a), .board(board_a), .turn(turn_a),
        .busy(busy_a), .move_ok(move_ok_a), .move_reject(move_reject_a),
        .winner(winner_a), .draw(draw_a), .game_over(game_over_a), .move_count(move_count_a)
    );

    gomoku_move_engine #(.BOARD_N(4), .PLAYERS(3), .WIN_LEN(3)) dut_b (
        .clock(clock), .reset(reset), .coord_x(coord_x_b), .coord_y(coord_y_b),
        .put(put_b), .new_game(new_game_b), .board(board_b), .turn(turn_b),
        .busy(busy_b), .move_ok(move_ok_b), .move_reject(move_reject_b),
        .winner(winner_b), .draw(draw_b), .game_over(game_over_b), .move_count(move_count_b)
    );

    gomoku_move_engine #(.BOARD_N(5), .PLAYERS(2), .WIN_LEN(3)) dut_c (
        .clock(clock), .reset(reset), .coord_x(coord_x_c), .coord_y(coord_y_c),
        .put(put_c), .new_game(new_game_c), .board(board_c), .turn(turn_c),
        .busy(busy_c), .move_ok(move_ok_c), .move_reject(move_reject_c),
        .winner(winner_c), .draw(draw_c), .game_over(game_over_c), .move_count(move_count_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // st: 0 = no response within budget, 1 = move_ok, 2 = move_reject; lat in cycles after the put edge
    task automatic put_a_move(input int x, input int y, output int st, output int lat);
        @(negedge clock);
        coord_x_a = 4'(x); coord_y_a = 4'(y); put_a = 1'b1;
        @(negedge clock);
        put_a = 1'b0;
        st = 0; lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            if (move_reject_a) begin st = 2; lat = i; break; end
            if (move_ok_a) begin st = 1; lat = i; break; end
        end
    endtask

    task automatic put_b_move(input int x, input int y, output int st, output int lat);
        @(negedge clock);
        coord_x_b = 2'(x); coord_y_b = 2'(y); put_b = 1'b1;
        @(negedge clock);
        put_b = 1'b0;
        st = 0; lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            if (move_reject_b) begin st = 2; lat = i; break; end
            if (move_ok_b) begin st = 1; lat = i; break; end
        end
    endtask

    task automatic put_c_move(input int x, input int y, output int st, output int lat);
        @(negedge clock);
        coord_x_c = 3'(x); coord_y_c = 3'(y); put_c = 1'b1;
        @(negedge clock);
        put_c = 1'b0;
        st = 0; lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            if (move_reject_c) begin st = 2; lat = i; break; end
            if (move_ok_c) begin st = 1; lat = i; break; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st, lat, seen;
        logic [511:0] exp_a;
        logic [31:0]  exp_b;
        int ax [10] = '{10, 3, 10, 3, 12, 3, 12, 3, 14, 3};
        int ay [10] = '{10, 0, 12, 1, 0, 2, 2, 3, 0, 4};
        int wx [9]  = '{3, 3, 0, 0, 2, 1, 1, 0, 2};
        int wy [9]  = '{3, 1, 2, 0, 3, 1, 3, 1, 0};
        int dx [16] = '{0, 0, 1, 0, 0, 1, 1, 2, 2, 1, 2, 2, 3, 3, 3, 3};
        int dy [16] = '{0, 2, 0, 1, 3, 1, 2, 0, 2, 3, 1, 3, 0, 3, 2, 1};

        reset = 1'b1;
        put_a = 1'b0; new_game_a = 1'b0; coord_x_a = '0; coord_y_a = '0;
        put_b = 1'b0; new_game_b = 1'b0; coord_x_b = '0; coord_y_b = '0;
        put_c = 1'b0; new_game_c = 1'b0; coord_x_c = '0; coord_y_c = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check_eq("rst_board", board_a, '0);
        check_eq("rst_turn", turn_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_move_ok", move_ok_a, 0);
        check_eq("rst_move_reject", move_reject_a, 0);
        check_eq("rst_winner", winner_a, 0);
        check_eq("rst_draw", draw_a, 0);
        check_eq("rst_game_over", game_over_a, 0);
        check_eq("rst_move_count", move_count_a, 0);

        // first move at the centre: full 37-cycle latency
        exp_a = '0;
        put_a_move(7, 7, st, lat);
        check_eq("a1_status", st, 1);
        check_eq("a1_latency", lat, 37);
        exp_a[(7*16+7)*2 +: 2] = 2'd1;
        check_eq("a1_cell", board_a[(7*16+7)*2 +: 2], 1);
        check_eq("a1_board", board_a, exp_a);
        check_eq("a1_turn", turn_a, 1);
        check_eq("a1_count", move_count_a, 1);
        check_eq("a1_busy", busy_a, 0);

        put_a_move(7, 7, st, lat);
        check_eq("a2_status", st, 2);
        check_eq("a2_latency", lat, 1);
        check_eq("a2_board", board_a, exp_a);
        check_eq("a2_turn", turn_a, 1);
        check_eq("a2_count", move_count_a, 1);

        // player 1 moves first here; player 0 completes row 3 columns 0..4
        for (int i = 0; i < 10; i++) begin
            put_a_move(ax[i], ay[i], st, lat);
            check_eq("awin_status", st, 1);
            exp_a[(ax[i]*16+ay[i])*2 +: 2] = (i % 2 == 0) ? 2'd2 : 2'd1;
            if (i == 8) check_eq("awin_no_early_winner", winner_a, 0);
        end
        check_eq("awin_winner", winner_a, 1);
        check_eq("awin_game_over", game_over_a, 1);
        check_eq("awin_draw", draw_a, 0);
        check_eq("awin_turn_frozen", turn_a, 0);
        check_eq("awin_count", move_count_a, 11);
        check_eq("awin_board", board_a, exp_a);
        put_a_move(0, 15, st, lat);
        check_eq("aover_status", st, 2);
        check_eq("aover_board", board_a, exp_a);

        @(negedge clock); new_game_a = 1'b1;
        @(negedge clock); new_game_a = 1'b0;
        check_eq("ng_board", board_a, '0);
        check_eq("ng_winner", winner_a, 0);
        check_eq("ng_game_over", game_over_a, 0);
        check_eq("ng_count", move_count_a, 0);
        check_eq("ng_turn", turn_a, 0);

        // new_game while the corner move is mid-scan
        @(negedge clock);
        coord_x_a = 4'd15; coord_y_a = 4'd15; put_a = 1'b1;
        @(negedge clock); put_a = 1'b0;
        repeat (10) @(negedge clock);
        check_eq("abort_busy_before", busy_a, 1);
        new_game_a = 1'b1;
        @(negedge clock); new_game_a = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clock);
            if (move_ok_a || move_reject_a) seen = 1;
        end
        check_eq("abort_no_result", seen, 0);
        check_eq("abort_board", board_a, '0);
        check_eq("abort_turn", turn_a, 0);
        check_eq("abort_count", move_count_a, 0);
        check_eq("abort_busy", busy_a, 0);
        put_a_move(15, 15, st, lat);
        check_eq("corner_status", st, 1);
        check_eq("corner_latency", lat, 37);
        check_eq("corner_cell", board_a[(15*16+15)*2 +: 2], 1);
        check_eq("corner_turn", turn_a, 1);

        // 3 players on 4x4, win length 3: player 2 completes the anti-diagonal
        check_eq("b_rst_turn", turn_b, 0);
        for (int i = 0; i < 9; i++) begin
            put_b_move(wx[i], wy[i], st, lat);
            check_eq("bwin_status", st, 1);
            if (i == 0) check_eq("b_latency", lat, 21);
        end
        check_eq("bwin_winner", winner_b, 3);
        check_eq("bwin_game_over", game_over_b, 1);
        check_eq("bwin_turn_frozen", turn_b, 2);
        check_eq("bwin_count", move_count_b, 9);

        @(negedge clock); new_game_b = 1'b1;
        @(negedge clock); new_game_b = 1'b0;
        check_eq("b_ng_turn", turn_b, 0);
        check_eq("b_ng_board", board_b, '0);

        exp_b = '0;
        for (int j = 0; j < 16; j++) begin
            put_b_move(dx[j], dy[j], st, lat);
            check_eq("bdraw_status", st, 1);
            exp_b[(dx[j]*4+dy[j])*2 +: 2] = 2'((j % 3) + 1);
            if (j == 14) check_eq("bdraw_not_yet", game_over_b, 0);
        end
        check_eq("bdraw_draw", draw_b, 1);
        check_eq("bdraw_winner", winner_b, 0);
        check_eq("bdraw_game_over", game_over_b, 1);
        check_eq("bdraw_count", move_count_b, 16);
        check_eq("bdraw_turn", turn_b, 0);
        check_eq("bdraw_board", board_b, exp_b);
        put_b_move(0, 0, st, lat);
        check_eq("bdraw_reject", st, 2);

        // 5x5 board: x = 5 is off the board
        put_c_move(5, 0, st, lat);
        check_eq("c_oob_status", st, 2);
        check_eq("c_oob_latency", lat, 1);
        check_eq("c_oob_count", move_count_c, 0);
        check_eq("c_oob_board", board_c, '0);
        put_c_move(4, 4, st, lat);
        check_eq("c_edge_status", st, 1);
        check_eq("c_edge_latency", lat, 21);
        check_eq("c_edge_cell", board_c[49:48], 1);
        check_eq("c_edge_turn", turn_c, 1);

        // asynchronous reset in the middle of a scan
        @(negedge clock);
        coord_x_a = 4'd0; coord_y_a = 4'd0; put_a = 1'b1;
        @(negedge clock); put_a = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("mrst_busy_async", busy_a, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("mrst_board", board_a, '0);
        check_eq("mrst_turn", turn_a, 0);
        check_eq("mrst_busy", busy_a, 0);
        check_eq("mrst_move_ok", move_ok_a, 0);
        check_eq("mrst_move_reject", move_reject_a, 0);
        check_eq("mrst_winner", winner_a, 0);
        check_eq("mrst_draw", draw_a, 0);
        check_eq("mrst_game_over", game_over_a, 0);
        check_eq("mrst_count", move_count_a, 0);
        put_a_move(1, 1, st, lat);
        check_eq("mrst_next_status", st, 1);
        check_eq("mrst_next_latency", lat, 37);
        check_eq("mrst_next_cell", board_a[(1*16+1)*2 +: 2], 1);
        check_eq("mrst_next_turn", turn_a, 1);
        check_eq("mrst_next_count", move_count_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
